// File: rtl/rv_mul_pkg.sv
// Shared definitions for the RV32M multiply sequencer: funct3 codes, FSM state type
// and operand-signedness / result-word helpers.
package rv_mul_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mul_state_t;

    // All four 0xx encodings are implemented; MULHSU is always present in this revision.
    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3[2] == 1'b0);
    endfunction

    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH);
    endfunction

    function automatic logic sel_high_word(input logic [2:0] f3);
        return (f3 != F3_MUL);
    endfunction

endpackage

// File: rtl/mul_datapath.sv
// Shift-add multiply datapath: operand magnitudes, 2*XLEN accumulator, sign fix-up and word select.
// MUL_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_datapath
    import rv_mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            load_illegal,
    input  logic            step,
    input  logic            last_step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd,
    output logic            finish,
    output logic [4:0]      resp_rd,
    output logic [XLEN-1:0] resp_data
);

    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   mplier;
    logic              neg;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;

    // Most negative value maps to itself, which is its correct unsigned magnitude.
    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                  input logic is_signed);
        logic signed [XLEN-1:0] m;
        m = (is_signed && (v < 0)) ? -v : v;
        return m;
    endfunction

    function automatic logic [2*XLEN-1:0] sign_fix(input logic [2*XLEN-1:0] p,
                                                   input logic negate);
        return negate ? (~p + 1'b1) : p;
    endfunction

    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign product  = sign_fix(acc_next, neg);

`ifdef MUL_EARLY_OUT_EN
    assign finish = last_step || (mplier[XLEN-1:1] == '0);
`else
    assign finish = last_step;
`endif

    always_ff @(posedge clk) begin
        if (load) begin
            mcand  <= {{XLEN{1'b0}}, magnitude(rs1, rs1_is_signed(funct3))};
            mplier <= magnitude(rs2, rs2_is_signed(funct3));
            acc    <= '0;
            neg    <= (rs1_is_signed(funct3) & rs1[XLEN-1]) ^ (rs2_is_signed(funct3) & rs2[XLEN-1]);
            f3_q   <= funct3;
            rd_q   <= rd;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Response registers hold between responses; only a completing or illegal op updates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rd   <= '0;
            resp_data <= '0;
        end else if (load_illegal) begin
            resp_rd   <= rd;
            resp_data <= '0;
        end else if (step && finish) begin
            resp_rd   <= rd_q;
            resp_data <= sel_high_word(f3_q) ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// RV32M multiply sequencer: FSM, iteration counter, request handshake, flush and stall.
// MUL_EARLY_OUT_EN enables the early-finish path in mul_datapath.
module mul_sequencer
    import rv_mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            stall,
    output logic            resp_valid,
    output logic [4:0]      resp_rd,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_illegal
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    mul_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             resp_valid_q;
    logic             accept;
    logic             accept_illegal;
    logic             step;
    logic             last_step;
    logic             finish;

    assign accept         = (state == IDLE) && req_valid && !flush;
    assign accept_illegal = accept && !f3_legal(req_funct3);
    assign step           = (state == CALC) && !flush;
    assign last_step      = (cnt == CNT_W'(XLEN - 1));

    assign req_ready  = (state == IDLE);
    assign stall      = (state != IDLE);
    // A flush arriving while DONE is presented kills that response in the same cycle.
    assign resp_valid = resp_valid_q && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            resp_valid_q <= 1'b0;
            resp_illegal <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (req_valid) begin
                            cnt <= '0;
                            if (f3_legal(req_funct3)) begin
                                state <= CALC;
                            end else begin
                                state        <= DONE;
                                resp_valid_q <= 1'b1;
                                resp_illegal <= 1'b1;
                            end
                        end
                    end
                    CALC: begin
                        cnt <= cnt + CNT_W'(1);
                        if (finish) begin
                            state        <= DONE;
                            resp_valid_q <= 1'b1;
                            resp_illegal <= 1'b0;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    mul_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .load         (accept),
        .load_illegal (accept_illegal),
        .step         (step),
        .last_step    (last_step),
        .funct3       (req_funct3),
        .rs1          (req_rs1),
        .rs2          (req_rs2),
        .rd           (req_rd),
        .finish       (finish),
        .resp_rd      (resp_rd),
        .resp_data    (resp_data)
    );

endmodule
